ifu_prefetch: RTL and testbench

Instruction prefetch stage between instruction memory and decode/execute. It issues word fetches to a variable-latency instruction memory over a req/ack handshake and buffers returned instructions with their PCs in a small FIFO. It presents them to decode with a valid/ready handshake, and flushes and refetches on a branch/jump redirect from execute. It replaces the direct combinational IM-to-datapath path so memory latency is decoupled from the core.

---
 rtl/mips_pkg.sv | 13 +
 rtl/sync_fifo.sv | 45 ++++
 rtl/ifu_prefetch.sv | 121 ++++++++++++
 tb/tb_ifu_prefetch.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared fetch-side definitions: reset PC, PC increment and the fetch FSM encoding.
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush; storage is cleared only by reset so the head reads 0 afterwards.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction prefetch: one outstanding word fetch at a time, results queued with their PCs,
// flushed and refetched on a redirect from execute.
module ifu_prefetch
  import mips_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  output logic         mem_req,
  output logic [31:0]  mem_addr,
  input  logic         mem_ack,
  input  logic [31:0]  mem_rdata,
  output logic         instr_valid,
  output logic [31:0]  instr,
  output logic [31:0]  instr_pc,
  input  logic         instr_ready,
  input  logic         redirect,
  input  logic [31:0]  redirect_pc,
  output fetch_state_e fetch_state
);

  localparam int CW = $clog2(DEPTH) + 1;

  // Handshakes: memory transfers on mem_req & mem_ack, and mem_req/mem_addr never change while
  // waiting for the ack; decode transfers on instr_valid & instr_ready. redirect beats both.

  fetch_state_e   state;
  fetch_state_e   state_next;
  logic [31:0]    fetch_pc;
  logic [31:0]    fetch_pc_next;
  logic           mem_req_next;
  logic [31:0]    mem_addr_next;
  logic [31:0]    redirect_target;
  logic           push;
  logic           pop;
  logic [CW-1:0]  count;
  logic [CW-1:0]  count_next;
  logic           room;
  logic [63:0]    head;
  logic           unused_pc_bits;

  assign redirect_target = {redirect_pc[31:2], 2'b00};
  assign unused_pc_bits  = ^redirect_pc[1:0];

  assign push        = (state == WAIT) & mem_ack & ~redirect;
  assign pop         = instr_valid & instr_ready & ~redirect;
  assign count_next  = count + CW'(push) - CW'(pop);
  assign room        = (count_next < CW'(DEPTH));
  assign instr_valid = (count != '0);
  assign instr_pc    = head[63:32];
  assign instr       = head[31:0];
  assign fetch_state = state;

  sync_fifo #(
    .WIDTH (64),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (redirect),
    .push  (push),
    .wdata ({mem_addr, mem_rdata}),
    .pop   (pop),
    .rdata (head),
    .count (count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      mem_req  <= 1'b0;
      mem_addr <= RESET_PC;
      fetch_pc <= RESET_PC;
    end else begin
      state    <= state_next;
      mem_req  <= mem_req_next;
      mem_addr <= mem_addr_next;
      fetch_pc <= fetch_pc_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (!redirect && room) state_next = WAIT;
      WAIT: begin
        if (mem_ack)       state_next = (!redirect && room) ? WAIT : IDLE;
        else if (redirect) state_next = DROP;
      end
      DROP: if (mem_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A request already on the bus is never withdrawn: only the ack releases mem_req.
  always_comb begin
    mem_req_next  = mem_req;
    mem_addr_next = mem_addr;
    fetch_pc_next = redirect ? redirect_target : fetch_pc;
    case (state)
      IDLE: begin
        if (!redirect && room) begin
          mem_req_next  = 1'b1;
          mem_addr_next = fetch_pc;
        end
      end
      WAIT: begin
        if (mem_ack) begin
          if (!redirect) fetch_pc_next = mem_addr + PC_STEP;
          if (!redirect && room) mem_addr_next = mem_addr + PC_STEP;
          else                   mem_req_next  = 1'b0;
        end
      end
      DROP: if (mem_ack) mem_req_next = 1'b0;
      default: mem_req_next = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_ifu_prefetch.sv
// Bench for ifu_prefetch: directed scenarios plus randomized traffic against a queue-based model.
module tb_ifu_prefetch;
  import mips_pkg::*;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ack;
  logic [31:0]  mem_rdata;
  logic         instr_valid;
  logic [31:0]  instr;
  logic [31:0]  instr_pc;
  logic         instr_ready;
  logic         redirect;
  logic [31:0]  redirect_pc;
  fetch_state_e fetch_state;

  always #5 clk = ~clk;

  ifu_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .fetch_state (fetch_state)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // exp_q holds {pc, instr} in decode order; the model tracks the single outstanding request.
  logic [63:0] exp_q[$];
  logic [31:0] m_fetch_pc;
  logic [31:0] m_addr;
  bit          m_req;
  bit          m_discard;
  logic [31:0] acked_q[$];
  logic [63:0] pop_log[$];

  task automatic model_init();
    exp_q.delete();
    m_fetch_pc = RESET_PC;
    m_addr     = RESET_PC;
    m_req      = 1'b0;
    m_discard  = 1'b0;
  endtask

  task automatic model_step();
    bit do_pop;
    bit acked;
    do_pop = (exp_q.size() != 0) && instr_ready && !redirect;
    acked  = m_req && mem_ack;
    if (acked) acked_q.push_back(m_addr);
    if (do_pop) begin
      pop_log.push_back(exp_q[0]);
      void'(exp_q.pop_front());
    end
    if (redirect) begin
      exp_q.delete();
      m_fetch_pc = {redirect_pc[31:2], 2'b00};
      if (acked) begin
        m_req     = 1'b0;
        m_discard = 1'b0;
      end else if (m_req) begin
        m_discard = 1'b1;
      end
    end else if (acked) begin
      if (m_discard) begin
        m_discard = 1'b0;
        m_req     = 1'b0;
      end else begin
        exp_q.push_back({m_addr, mem_rdata});
        m_fetch_pc = m_addr + 32'd4;
        if (exp_q.size() < DEPTH) m_addr = m_fetch_pc;
        else                      m_req  = 1'b0;
      end
    end else if (!m_req && exp_q.size() < DEPTH) begin
      m_req  = 1'b1;
      m_addr = m_fetch_pc;
    end
  endtask

  initial begin
    model_init();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_init();
      else       model_step();
    end
  end

  // ---------------- scoreboard compare ----------------
  initial begin
    fetch_state_e exp_st;
    forever begin
      @(negedge clk);
      if (!reset) begin
        exp_st = !m_req ? IDLE : (m_discard ? DROP : WAIT);
        chk("mem_req", 32'(mem_req), 32'(m_req));
        chk("mem_addr", mem_addr, m_addr);
        chk("instr_valid", 32'(instr_valid), 32'(exp_q.size() != 0));
        chk("fetch_state", 32'(fetch_state), 32'(exp_st));
        if (exp_q.size() != 0) begin
          chk("instr_pc", instr_pc, exp_q[0][63:32]);
          chk("instr", instr, exp_q[0][31:0]);
        end
      end
    end
  end

  function automatic logic [31:0] aq(input int i);
    return (i < acked_q.size()) ? acked_q[i] : 32'hDEAD_DEAD;
  endfunction

  function automatic logic [31:0] pq_pc(input int i);
    return (i < pop_log.size()) ? pop_log[i][63:32] : 32'hDEAD_DEAD;
  endfunction

  function automatic logic [31:0] pq_in(input int i);
    return (i < pop_log.size()) ? pop_log[i][31:0] : 32'hDEAD_DEAD;
  endfunction

  // ---------------- driver: memory responder + decode side ----------------
  int          lat_min = 0;
  int          lat_max = 0;
  int          lat = 0;
  int          wait_cnt = 0;
  logic [31:0] salt = 32'h0;

  // Called at a negedge; drives one cycle of inputs and returns at the following negedge.
  task automatic step(input bit rdy, input bit redir, input logic [31:0] rpc);
    bit req_s;
    req_s       = mem_req;
    instr_ready = rdy;
    redirect    = redir;
    redirect_pc = rpc;
    mem_ack     = req_s && (wait_cnt >= lat);
    mem_rdata   = mem_ack ? (mem_addr ^ salt) : $urandom();
    @(posedge clk);
    if (mem_ack) begin
      wait_cnt = 0;
      lat      = $urandom_range(lat_max, lat_min);
    end else if (req_s) begin
      wait_cnt++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    mem_ack     = 1'b0;
    mem_rdata   = 32'h0;
    wait_cnt    = 0;
    lat         = lat_min;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    acked_q.delete();
    pop_log.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    bit          rdy;
    bit          redir;
    logic [31:0] rpc;

    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    mem_ack     = 1'b0;
    mem_rdata   = 32'h0;

    // Zero-wait memory returning the address, decode always ready.
    lat_min = 0; lat_max = 0; salt = 32'h0;
    do_reset();
    chk("rst mem_req", 32'(mem_req), 32'h0);
    chk("rst mem_addr", mem_addr, 32'h0000_3000);
    chk("rst instr_valid", 32'(instr_valid), 32'h0);
    chk("rst instr", instr, 32'h0);
    chk("rst instr_pc", instr_pc, 32'h0);
    repeat (10) step(1'b1, 1'b0, 32'h0);
    chk("t1 pops", 32'(pop_log.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk("t1 pop pc", pq_pc(i), 32'h0000_3000 + 32'(4 * i));
      chk("t1 pop instr", pq_in(i), 32'h0000_3000 + 32'(4 * i));
    end
    for (int i = 0; i < 5; i++) chk("t1 req addr", aq(i), 32'h0000_3000 + 32'(4 * i));

    // Decode stalled: fill to DEPTH, then resume.
    do_reset();
    repeat (10) step(1'b0, 1'b0, 32'h0);
    chk("t2 acked", 32'(acked_q.size()), 32'd4);
    chk("t2 last req", aq(3), 32'h0000_300C);
    chk("t2 mem_req", 32'(mem_req), 32'h0);
    chk("t2 instr_valid", 32'(instr_valid), 32'h1);
    chk("t2 head pc", instr_pc, 32'h0000_3000);
    repeat (8) step(1'b1, 1'b0, 32'h0);
    chk("t2 resume addr", aq(4), 32'h0000_3010);
    chk("t2 pops", 32'(pop_log.size() >= 5), 32'h1);
    for (int i = 0; i < pop_log.size(); i++)
      chk("t2 pop pc", pq_pc(i), 32'h0000_3000 + 32'(4 * i));

    // 3-cycle latency, redirect during the second wait cycle.
    lat_min = 3; lat_max = 3;
    do_reset();
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h0000_4000);
    chk("t3 held req", 32'(mem_req), 32'h1);
    chk("t3 held addr", mem_addr, 32'h0000_3000);
    chk("t3 drop state", 32'(fetch_state), 32'(DROP));
    repeat (14) step(1'b1, 1'b0, 32'h0);
    chk("t3 dropped addr", aq(0), 32'h0000_3000);
    chk("t3 next req", aq(1), 32'h0000_4000);
    chk("t3 first pc", pq_pc(0), 32'h0000_4000);

    // Redirect coinciding with an ack and a pop.
    lat_min = 0; lat_max = 0;
    do_reset();
    repeat (5) step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h0000_5002);
    acked_q.delete();
    pop_log.delete();
    chk("t4 valid after flush", 32'(instr_valid), 32'h0);
    chk("t4 mem_req", 32'(mem_req), 32'h0);
    step(1'b1, 1'b0, 32'h0);
    chk("t4 new req", 32'(mem_req), 32'h1);
    chk("t4 new addr", mem_addr, 32'h0000_5000);
    repeat (4) step(1'b1, 1'b0, 32'h0);
    chk("t4 first pc", pq_pc(0), 32'h0000_5000);

    // Address wrap.
    step(1'b1, 1'b1, 32'hFFFF_FFF8);
    acked_q.delete();
    pop_log.delete();
    repeat (6) step(1'b1, 1'b0, 32'h0);
    chk("t5 wrap 0", aq(0), 32'hFFFF_FFF8);
    chk("t5 wrap 1", aq(1), 32'hFFFF_FFFC);
    chk("t5 wrap 2", aq(2), 32'h0000_0000);
    chk("t5 wrap pc", pq_pc(2), 32'h0000_0000);

    // Asynchronous reset while a request is outstanding with two entries buffered.
    do_reset();
    repeat (3) step(1'b0, 1'b0, 32'h0);
    chk("t6 pre valid", 32'(instr_valid), 32'h1);
    chk("t6 pre req", 32'(mem_req), 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("t6 async mem_req", 32'(mem_req), 32'h0);
    chk("t6 async valid", 32'(instr_valid), 32'h0);
    chk("t6 async instr", instr, 32'h0);
    chk("t6 async instr_pc", instr_pc, 32'h0);
    do_reset();
    repeat (4) step(1'b1, 1'b0, 32'h0);
    chk("t6 restart addr", aq(0), 32'h0000_3000);

    // Randomized traffic against the model.
    lat_min = 0; lat_max = 3; salt = $urandom();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rdy   = ($urandom_range(9, 0) < 7);
      redir = ($urandom_range(39, 0) == 0);
      rpc   = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(15, 0)))
                                          : $urandom();
      step(rdy, redir, rpc);
    end
    chk("rand progress", 32'(pop_log.size() > 100), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
